// File: rtl/carfield_pkg.sv
// Shared constants and types for the Carfield mailbox slave window.
package carfield_pkg;

  localparam int unsigned MailboxMaxChannels = 8;
  localparam logic [11:0] MailboxChanStride  = 12'h020;

  // Register selector, taken from addr[4:2] within a channel's 0x20 stride.
  typedef enum logic [2:0] {
    MboxDataW    = 3'd0,
    MboxDataR    = 3'd1,
    MboxStatus   = 3'd2,
    MboxDoorbell = 3'd3,
    MboxIrqEn    = 3'd4,
    MboxComplete = 3'd5,
    MboxIrqClr   = 3'd6
  } mbox_reg_e;

  typedef enum logic {
    MboxIdle = 1'b0,
    MboxResp = 1'b1
  } mbox_state_e;

  function automatic logic [31:0] mboxStatus(input logic empty, input logic full,
                                             input logic [7:0] count);
    return {16'h0000, count, 6'b000000, full, empty};
  endfunction

endpackage

// File: rtl/fifo_v3.sv
// Minimal common_cells-compatible FIFO (no fall-through); usage wraps to 0 when full.
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  localparam int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam logic [ADDR_DEPTH:0] CntOne  = (ADDR_DEPTH+1)'(1);
  localparam logic [ADDR_DEPTH:0] CntFull = (ADDR_DEPTH+1)'(DEPTH);
  localparam logic [ADDR_DEPTH-1:0] PtrOne = ADDR_DEPTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_DEPTH-1:0] readPtr, writePtr;
  logic [ADDR_DEPTH:0]   count;
  logic                  doPush, doPop;

  assign full_o  = (count == CntFull);
  assign empty_o = (count == '0);
  assign usage_o = count[ADDR_DEPTH-1:0];
  assign data_o  = mem[readPtr];
  assign doPush  = push_i & ~full_o;
  assign doPop   = pop_i & ~empty_o;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      readPtr  <= '0;
      writePtr <= '0;
      count    <= '0;
    end else if (flush_i) begin
      readPtr  <= '0;
      writePtr <= '0;
      count    <= '0;
    end else begin
      if (doPush) writePtr <= writePtr + PtrOne;
      if (doPop)  readPtr  <= readPtr + PtrOne;
      case ({doPush, doPop})
        2'b10:   count <= count + CntOne;
        2'b01:   count <= count - CntOne;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset; the pointers and count
  // already make stale words unreachable, and a reset here would cost a flop
  // reset per bit.
  always_ff @(posedge clk_i) begin
    if (doPush) mem[writePtr] <= data_i;
  end

endmodule

// File: rtl/carfield_mailbox_slv.sv
// Mailbox slave window: per-channel message FIFO, doorbell, completion flag and
// level interrupts behind a one-request-per-two-cycles register bus.
module carfield_mailbox_slv
  import carfield_pkg::*;
#(
  parameter int unsigned NumChannels = 4,
  parameter int unsigned FifoDepth   = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  input  logic                   req_write_i,
  input  logic [11:0]            req_addr_i,
  input  logic [31:0]            req_wdata_i,
  input  logic [3:0]             req_wstrb_i,
  output logic                   req_ready_o,
  output logic [31:0]            rsp_rdata_o,
  output logic                   rsp_error_o,
  output logic [NumChannels-1:0] irq_rx_o,
  output logic [NumChannels-1:0] irq_tx_o
);

  localparam int unsigned AddrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned ChanW = $clog2(MailboxMaxChannels);
  localparam logic [11:0] WindowEnd = 12'(NumChannels) * MailboxChanStride;

  mbox_state_e            stateQ;
  logic [NumChannels-1:0] doorbellQ, completionQ, enRxQ, enTxQ;
  logic [NumChannels-1:0] doorbellD, completionD, enRxD, enTxD;
  logic [NumChannels-1:0] fifoFull, fifoEmpty, fifoPush, fifoPop;
  logic [AddrW-1:0]       fifoUsage [NumChannels];
  logic [31:0]            fifoData  [NumChannels];

  logic             accept, inRange, byte0, fullWord;
  logic [ChanW-1:0] chanSel;
  mbox_reg_e        regSel;
  logic [31:0]      rdataD;
  logic             errD;

  assign accept   = (stateQ == MboxIdle) && req_valid_i;
  assign inRange  = req_addr_i < WindowEnd;
  assign chanSel  = req_addr_i[7:5];
  assign regSel   = mbox_reg_e'(req_addr_i[4:2]);
  assign byte0    = req_wstrb_i[0];
  assign fullWord = (req_wstrb_i == 4'hF);

  for (genvar c = 0; c < NumChannels; c++) begin : gen_fifo
    fifo_v3 #(
      .DATA_WIDTH(32),
      .DEPTH     (FifoDepth)
    ) i_fifo (
      .clk_i  (clk_i),
      .rst_ni (~rst_i),
      .flush_i(1'b0),
      .full_o (fifoFull[c]),
      .empty_o(fifoEmpty[c]),
      .usage_o(fifoUsage[c]),
      .data_i (req_wdata_i),
      .push_i (fifoPush[c]),
      .data_o (fifoData[c]),
      .pop_i  (fifoPop[c])
    );
  end

  // NOTE: every signal driven here gets a default before any branch, so no
  // path through the decode can leave a value held and infer a latch.
  always_comb begin
    doorbellD   = doorbellQ;
    completionD = completionQ;
    enRxD       = enRxQ;
    enTxD       = enTxQ;
    fifoPush    = '0;
    fifoPop     = '0;
    rdataD      = '0;
    errD        = 1'b0;
    if (accept) begin
      if (!inRange) begin
        errD = 1'b1;
      end else begin
        for (int c = 0; c < NumChannels; c++) begin
          if (chanSel == ChanW'(c)) begin
            case (regSel)
              MboxDataW: begin
                if (!req_write_i || fifoFull[c] || !fullWord) errD = 1'b1;
                else fifoPush[c] = 1'b1;
              end
              MboxDataR: begin
                if (req_write_i || fifoEmpty[c]) begin
                  errD = 1'b1;
                end else begin
                  fifoPop[c] = 1'b1;
                  rdataD     = fifoData[c];
                end
              end
              MboxStatus: begin
                if (req_write_i) errD = 1'b1;
                else rdataD = mboxStatus(fifoEmpty[c], fifoFull[c],
                                         8'({fifoFull[c], fifoUsage[c]}));
              end
              MboxDoorbell: begin
                if (req_write_i) begin
                  if (byte0 && req_wdata_i[0]) doorbellD[c] = 1'b1;
                end else begin
                  rdataD = {31'b0, doorbellQ[c]};
                end
              end
              MboxIrqEn: begin
                if (req_write_i) begin
                  if (byte0) begin
                    enRxD[c] = req_wdata_i[0];
                    enTxD[c] = req_wdata_i[1];
                  end
                end else begin
                  rdataD = {30'b0, enTxQ[c], enRxQ[c]};
                end
              end
              MboxComplete: begin
                if (req_write_i) begin
                  if (byte0 && req_wdata_i[0]) completionD[c] = 1'b1;
                end else begin
                  rdataD = {31'b0, completionQ[c]};
                end
              end
              MboxIrqClr: begin
                if (req_write_i && byte0) begin
                  if (req_wdata_i[0]) doorbellD[c]   = 1'b0;
                  if (req_wdata_i[1]) completionD[c] = 1'b0;
                end
              end
              default: errD = 1'b1;
            endcase
          end
        end
      end
    end
  end

  // Interrupts are registered from next-state values so they change together
  // with req_ready_o rather than one cycle behind it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stateQ      <= MboxIdle;
      req_ready_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_error_o <= 1'b0;
      doorbellQ   <= '0;
      completionQ <= '0;
      enRxQ       <= '0;
      enTxQ       <= '0;
      irq_rx_o    <= '0;
      irq_tx_o    <= '0;
    end else begin
      doorbellQ   <= doorbellD;
      completionQ <= completionD;
      enRxQ       <= enRxD;
      enTxQ       <= enTxD;
      irq_rx_o    <= doorbellD & enRxD;
      irq_tx_o    <= completionD & enTxD;
      case (stateQ)
        MboxIdle: begin
          req_ready_o <= 1'b0;
          if (req_valid_i) begin
            stateQ      <= MboxResp;
            req_ready_o <= 1'b1;
            rsp_rdata_o <= rdataD;
            rsp_error_o <= errD;
          end
        end
        MboxResp: begin
          stateQ      <= MboxIdle;
          req_ready_o <= 1'b0;
        end
        default: begin
          stateQ      <= MboxIdle;
          req_ready_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_carfield_mailbox_slv.sv
// Directed bench for carfield_mailbox_slv (NumChannels=4, FifoDepth=4).
module tb_carfield_mailbox_slv;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_write_i;
  logic [11:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [3:0]  req_wstrb_i;
  logic        req_ready_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_error_o;
  logic [3:0]  irq_rx_o;
  logic [3:0]  irq_tx_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0] gotRdata;
  logic        gotErr;
  logic [3:0]  gotRx, gotTx;

  carfield_mailbox_slv #(.NumChannels(4), .FifoDepth(4)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_valid_i(req_valid_i),
    .req_write_i(req_write_i),
    .req_addr_i (req_addr_i),
    .req_wdata_i(req_wdata_i),
    .req_wstrb_i(req_wstrb_i),
    .req_ready_o(req_ready_o),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_error_o(rsp_error_o),
    .irq_rx_o   (irq_rx_o),
    .irq_tx_o   (irq_tx_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Issue one request starting just after a rising edge and capture the
  // response in the req_ready_o cycle; then confirm ready lasts one cycle.
  task automatic doReq(input logic wr, input logic [11:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
    bit seen = 0;
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_wstrb_i = wstrb;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_i);
      #1;
      if (req_ready_o) begin
        seen = 1;
        break;
      end
    end
    gotRdata    = rsp_rdata_o;
    gotErr      = rsp_error_o;
    gotRx       = irq_rx_o;
    gotTx       = irq_tx_o;
    req_valid_i = 1'b0;
    if (!seen) check("ready_timeout", 32'(seen), 32'd1);
    @(posedge clk_i);
    #1;
    check("ready_one_cycle", 32'(req_ready_o), 32'd0);
  endtask

  initial begin
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_write_i = 1'b0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    req_wstrb_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_ready", 32'(req_ready_o), 32'd0);
    check("rst_rdata", rsp_rdata_o, 32'd0);
    check("rst_error", 32'(rsp_error_o), 32'd0);
    check("rst_irq_rx", 32'(irq_rx_o), 32'd0);
    check("rst_irq_tx", 32'(irq_tx_o), 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    doReq(1'b0, 12'h008, 32'h0, 4'hF);
    check("ch0_status_empty", gotRdata, 32'h0000_0001);
    check("ch0_status_err", 32'(gotErr), 32'd0);

    // Channel 1 FIFO ordering
    doReq(1'b1, 12'h020, 32'hA5A5_0001, 4'hF);
    check("ch1_push1_err", 32'(gotErr), 32'd0);
    doReq(1'b1, 12'h020, 32'hA5A5_0002, 4'hF);
    check("ch1_push2_err", 32'(gotErr), 32'd0);
    doReq(1'b0, 12'h028, 32'h0, 4'hF);
    check("ch1_status_two", gotRdata, 32'h0000_0200);
    doReq(1'b0, 12'h024, 32'h0, 4'hF);
    check("ch1_pop1", gotRdata, 32'hA5A5_0001);
    check("ch1_pop1_err", 32'(gotErr), 32'd0);
    doReq(1'b0, 12'h024, 32'h0, 4'hF);
    check("ch1_pop2", gotRdata, 32'hA5A5_0002);
    doReq(1'b0, 12'h028, 32'h0, 4'hF);
    check("ch1_status_empty", gotRdata, 32'h0000_0001);

    // Channel 0 fill, overflow, drain, underflow
    doReq(1'b1, 12'h000, 32'h1111_0001, 4'hF);
    doReq(1'b1, 12'h000, 32'h1111_0002, 4'hF);
    doReq(1'b1, 12'h000, 32'h1111_0003, 4'hF);
    doReq(1'b1, 12'h000, 32'h1111_0004, 4'hF);
    check("ch0_push4_err", 32'(gotErr), 32'd0);
    doReq(1'b1, 12'h000, 32'h1111_0005, 4'hF);
    check("ch0_push_full_err", 32'(gotErr), 32'd1);
    doReq(1'b0, 12'h008, 32'h0, 4'hF);
    check("ch0_status_full", gotRdata, 32'h0000_0402);
    doReq(1'b0, 12'h004, 32'h0, 4'hF);
    check("ch0_pop1", gotRdata, 32'h1111_0001);
    doReq(1'b0, 12'h004, 32'h0, 4'hF);
    doReq(1'b0, 12'h004, 32'h0, 4'hF);
    check("ch0_pop3", gotRdata, 32'h1111_0003);
    doReq(1'b0, 12'h004, 32'h0, 4'hF);
    check("ch0_pop4", gotRdata, 32'h1111_0004);
    doReq(1'b0, 12'h004, 32'h0, 4'hF);
    check("ch0_pop_empty_err", 32'(gotErr), 32'd1);
    check("ch0_pop_empty_rdata", gotRdata, 32'd0);

    // Channel 2 interrupts
    doReq(1'b1, 12'h050, 32'h3, 4'hF);
    check("ch2_irqen_err", 32'(gotErr), 32'd0);
    doReq(1'b1, 12'h04C, 32'h1, 4'hF);
    check("ch2_doorbell_irq_rx", 32'(gotRx), 32'h4);
    check("ch2_doorbell_irq_tx", 32'(gotTx), 32'h0);
    doReq(1'b0, 12'h04C, 32'h0, 4'hF);
    check("ch2_doorbell_read", gotRdata, 32'h1);
    doReq(1'b1, 12'h058, 32'h1, 4'hF);
    check("ch2_clr_irq_rx", 32'(gotRx), 32'h0);
    doReq(1'b1, 12'h054, 32'h1, 4'hF);
    check("ch2_complete_irq_tx", 32'(gotTx), 32'h4);
    check("ch2_complete_irq_rx", 32'(gotRx), 32'h0);
    doReq(1'b0, 12'h054, 32'h0, 4'hF);
    check("ch2_complete_read", gotRdata, 32'h1);
    doReq(1'b0, 12'h050, 32'h0, 4'hF);
    check("ch2_irqen_read", gotRdata, 32'h3);
    doReq(1'b0, 12'h058, 32'h0, 4'hF);
    check("ch2_irqclr_read", gotRdata, 32'h0);

    // Error cases and the byte-0 strobe rule
    doReq(1'b0, 12'h080, 32'h0, 4'hF);
    check("oor_read_err", 32'(gotErr), 32'd1);
    check("oor_read_rdata", gotRdata, 32'd0);
    doReq(1'b1, 12'h080, 32'hFFFF_FFFF, 4'hF);
    check("oor_write_err", 32'(gotErr), 32'd1);
    doReq(1'b1, 12'h020, 32'hDEAD_BEEF, 4'h3);
    check("partial_push_err", 32'(gotErr), 32'd1);
    doReq(1'b0, 12'h028, 32'h0, 4'hF);
    check("partial_push_no_effect", gotRdata, 32'h0000_0001);
    doReq(1'b0, 12'h03C, 32'h0, 4'hF);
    check("rsvd_1c_err", 32'(gotErr), 32'd1);
    doReq(1'b0, 12'h020, 32'h0, 4'hF);
    check("read_dataw_err", 32'(gotErr), 32'd1);
    doReq(1'b1, 12'h028, 32'h0, 4'hF);
    check("write_status_err", 32'(gotErr), 32'd1);
    doReq(1'b1, 12'h02C, 32'h1, 4'hE);
    check("byte0_off_err", 32'(gotErr), 32'd0);
    doReq(1'b0, 12'h02C, 32'h0, 4'hF);
    check("byte0_off_no_doorbell", gotRdata, 32'd0);
    doReq(1'b1, 12'h02C, 32'h0, 4'hF);
    doReq(1'b0, 12'h02C, 32'h0, 4'hF);
    check("doorbell_write0_no_effect", gotRdata, 32'd0);

    // Reset during the response cycle of a channel-3 doorbell write
    doReq(1'b1, 12'h070, 32'h1, 4'hF);
    req_valid_i = 1'b1;
    req_write_i = 1'b1;
    req_addr_i  = 12'h06C;
    req_wdata_i = 32'h1;
    req_wstrb_i = 4'hF;
    @(posedge clk_i);
    #1;
    check("pre_rst_irq_rx", 32'(irq_rx_o), 32'h8);
    rst_i = 1'b1;
    #1;
    check("mid_rst_ready", 32'(req_ready_o), 32'd0);
    check("mid_rst_irq_rx", 32'(irq_rx_o), 32'd0);
    check("mid_rst_irq_tx", 32'(irq_tx_o), 32'd0);
    @(posedge clk_i);
    #1;
    check("mid_rst_ready_held", 32'(req_ready_o), 32'd0);
    rst_i       = 1'b0;
    req_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("post_rst_ready", 32'(req_ready_o), 32'd0);
    doReq(1'b0, 12'h06C, 32'h0, 4'hF);
    check("post_rst_doorbell", gotRdata, 32'd0);
    doReq(1'b0, 12'h070, 32'h0, 4'hF);
    check("post_rst_irqen", gotRdata, 32'd0);
    doReq(1'b0, 12'h008, 32'h0, 4'hF);
    check("post_rst_ch0_status", gotRdata, 32'h0000_0001);
    doReq(1'b1, 12'h070, 32'h1, 4'hF);
    doReq(1'b1, 12'h06C, 32'h1, 4'hF);
    check("retry_err", 32'(gotErr), 32'd0);
    check("retry_irq_rx", 32'(gotRx), 32'h8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/carfield_mailbox_slv.md
# carfield_mailbox_slv

Register-bus responder implementing the mailbox slave window at MailboxBase (4 KiB). It provides NumChannels independent inter-domain channels. Each channel has a 32-bit message FIFO, a doorbell and a completion flag, and drives two level interrupts toward receiver and sender. It sits behind the Cheshire AXI-to-regbus bridge on the Mailbox slave port. Its interrupt outputs feed the external interrupt inputs of the host and the islands.

## Interface
- NumChannels, default 4, number of channels (1..8).
- FifoDepth, default 4, message words per channel FIFO (power of two, ≥2).
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  request valid; held by the initiator until req_ready_o.
- req_write_i  in  1  1 = write, 0 = read.
- req_addr_i  in  12  byte offset within the window.
- req_wdata_i  in  32  write data.
- req_wstrb_i  in  4  byte strobes.
- req_ready_o  out  1  one-cycle response strobe.
- rsp_rdata_o  out  32  read data, valid with req_ready_o.
- rsp_error_o  out  1  slave error, valid with req_ready_o.
- irq_rx_o  out  NumChannels  per-channel doorbell interrupt, to the receiver.
- irq_tx_o  out  NumChannels  per-channel completion interrupt, to the sender.

## Operation
- Address decode:
  - channel = addr[7:5]; register = addr[4:2]; addr[1:0] ignored.
  - addr ≥ NumChannels·0x20 → error, no side effect, rdata 0.
- Per-channel registers (offset within 0x20 stride):
  - 0x00 DATA_W (WO): push wdata.
    - Error if the FIFO is full or wstrb ≠ 4'hF; no push in either case.
    - Read of DATA_W → error.
  - 0x04 DATA_R (RO): pop, return head word.
    - Empty → error, rdata 0, no pop.
    - Write → error.
  - 0x08 STATUS (RO): [0] empty, [1] full, [15:8] occupancy count. Write → error.
  - 0x0C DOORBELL: read returns [0] doorbell.
    - Write with wstrb[0] and wdata[0]=1 sets doorbell.
    - Writing 0 has no effect.
  - 0x10 IRQ_EN (RW): [0] rx enable, [1] tx enable.
  - 0x14 COMPLETE: write wdata[0]=1 sets the completion flag; read returns [0] completion.
  - 0x18 IRQ_CLR (W1C): [0] clears doorbell, [1] clears completion. Read returns 0.
  - 0x1C: error.
- Byte-0 registers: if wstrb[0]=0, the write is accepted without error and has no effect.
- Interrupts:
  - irq_rx_o[c] = doorbell[c] & en[c][0].
  - irq_tx_o[c] = completion[c] & en[c][1].
  - Both are registered and level-sensitive.
- FSM with two states:
  - IDLE: if req_valid_i, decode, commit the side effect at the clock edge, capture rdata/error, go to RESP.
  - RESP: assert req_ready_o for exactly one cycle, go to IDLE.
  - The request is never recommitted while valid is still high in RESP.
- FIFO pointers wrap modulo FifoDepth. The count is FifoDepth+1 states wide, so full and empty are distinguishable.
- A single port means push, pop, set and clear never coincide within a channel.

## Timing
- Reset values:
  - req_ready_o=0, rsp_rdata_o=0, rsp_error_o=0, irq_rx_o=0, irq_tx_o=0.
  - All FIFOs empty, doorbell/completion/IRQ_EN = 0, FSM in IDLE.
- Latency:
  - req_ready_o rises in the cycle after req_valid_i is first sampled high in IDLE.
  - Throughput is one transaction per 2 cycles.
- Register and interrupt updates:
  - Register state changes at the edge ending the IDLE accept cycle.
  - irq outputs reflect the change one cycle later, coincident with req_ready_o.
- Reset mid-transaction: everything returns to reset values immediately, no response is issued, and the pending request is dropped. The initiator reissues it after reset.

## Structure
- Constants belong in carfield_pkg:
  - MailboxChanStride = 'h20.
  - Register-offset enum mbox_reg_e (MboxDataW … MboxIrqClr).
  - MailboxMaxChannels = 8.
- Sub-module: one fifo_v3 (common_cells) per channel, DATA_WIDTH 32, DEPTH FifoDepth, driven with rst_ni = ~rst_i and flush tied 0.

## Test plan
- Reset → all outputs 0; a STATUS read of channel 0 returns 0x0000_0001 (empty).
- Write DATA_W ch1 = 0xA5A5_0001, 0xA5A5_0002 → STATUS = 0x0000_0200; DATA_R reads return them in order, then STATUS = 0x0000_0001.
- Fill ch0 with 4 words (FifoDepth=4), 5th push → rsp_error_o=1, STATUS = 0x0000_0402; then pop on an empty FIFO → error with rdata 0.
- IRQ_EN ch2 = 0x3, DOORBELL = 1 → irq_rx_o = 4'b0100 in the req_ready_o cycle; IRQ_CLR = 0x1 → irq_rx_o = 0; COMPLETE = 1 → irq_tx_o = 4'b0100.
- Access 0x080 with NumChannels=4, DATA_W with wstrb=4'h3, and offset 0x1C → all error, no state change.
- Assert rst_i during RESP after a DOORBELL write → req_ready_o stays 0, doorbell 0, irq 0; a retried write completes normally.
